// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator entry sequencer.
// Holds the controller state encoding, the keypad codes the sequencer reacts
// to, and the pattern shown on the display when the ALU times out.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT_DONE,
        SHOW,
        ERR
    } calc_state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_OP        = 4'hA;
    localparam logic [3:0] KEY_BS        = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] KEY_EQ        = 4'hE;

    localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

    // Codes 0x0-0x9 are numeric digits; everything above is a command or unused.
    function automatic logic is_digit_key(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/calc_sequencer_operand_entry.sv
// operand_entry: one BCD operand register built digit by digit.
// A new digit shifts in at the units position; the digit counter saturates at
// MAX_DIGITS so extra digits are dropped instead of pushing the top digit out.
// shift_back removes the units digit (used for backspace). When clear and load
// arrive together the operand restarts holding just the new digit.
module operand_entry #(
    parameter  int MAX_DIGITS = 3,
    localparam int W          = 4 * MAX_DIGITS,
    localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [3:0]    digit,
    input  logic          shift_back,
    input  logic          clear,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Operand shift register and saturating digit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (load && (clear || count < CW'(MAX_DIGITS))) begin
            if (clear) begin
                value <= {{(W-4){1'b0}}, digit};
                count <= CW'(1);
            end else begin
                value <= {value[W-5:0], digit};
                count <= count + 1'b1;
            end
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (shift_back && count != '0) begin
            value <= {4'h0, value[W-1:4]};
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven two-operand entry and ALU launch controller.
// Builds operands A and B from digit strobes, launches the ALU on '=', waits
// for its done strobe (with a timeout), and selects the display value.
// Optional feature: define CALC_BACKSPACE_EN to make key 0xB delete the last
// digit of the operand being entered; otherwise 0xB is ignored.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    alu_done,
    input  logic [15:0]             alu_result,
    output logic [4*MAX_DIGITS-1:0] op_a,
    output logic [4*MAX_DIGITS-1:0] op_b,
    output logic                    alu_start,
    output logic [15:0]             disp_value,
    output logic                    busy,
    output logic                    err
);

    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    calc_state_t   state;
    logic [15:0]   result;
    logic [TW-1:0] timer;

    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    logic key_digit;
    logic key_op;
    logic key_eq;
    logic key_clr;
`ifdef CALC_BACKSPACE_EN
    logic key_bs;
`endif

    logic         a_load;
    logic         a_clear;
    logic         a_back;
    logic         b_load;
    logic         b_clear;
    logic         b_back;
    logic [W-1:0] a_next;
    logic [W-1:0] b_next;

    // Value an operand register will hold after this edge; lets the display
    // register show the freshly entered digit in the same cycle as the operand.
    function automatic logic [W-1:0] entry_next(
        input logic [W-1:0]  v,
        input logic [CW-1:0] c,
        input logic          ld,
        input logic [3:0]    d,
        input logic          bk,
        input logic          cl
    );
        logic [W-1:0] nv;
        nv = cl ? '0 : v;
        if (ld && (cl || c < CW'(MAX_DIGITS))) begin
            nv = {nv[W-5:0], d};
        end else if (!cl && bk && c != '0) begin
            nv = {4'h0, nv[W-1:4]};
        end
        return nv;
    endfunction

    // Classify the incoming key strobe.
    always_comb begin
        key_digit = key_valid && is_digit_key(key_code);
        key_op    = key_valid && (key_code == KEY_OP);
        key_eq    = key_valid && (key_code == KEY_EQ);
        key_clr   = key_valid && (key_code == KEY_CLR);
`ifdef CALC_BACKSPACE_EN
        key_bs    = key_valid && (key_code == KEY_BS);
`endif
    end

    // Steer digit, backspace and clear actions to the operand registers.
    always_comb begin
        a_load  = 1'b0;
        a_back  = 1'b0;
        b_load  = 1'b0;
        b_back  = 1'b0;
        a_clear = key_clr;
        b_clear = key_clr;
        if (!key_clr) begin
            case (state)
                ENTER_A: begin
                    a_load = key_digit;
`ifdef CALC_BACKSPACE_EN
                    a_back = key_bs;
`endif
                end
                ENTER_B: begin
                    b_load = key_digit;
`ifdef CALC_BACKSPACE_EN
                    b_back = key_bs;
`endif
                end
                SHOW: begin
                    if (key_digit) begin
                        a_clear = 1'b1;
                        b_clear = 1'b1;
                        a_load  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
        a_next = entry_next(op_a, a_count, a_load, key_code, a_back, a_clear);
        b_next = entry_next(op_b, b_count, b_load, key_code, b_back, b_clear);
    end

    operand_entry #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_entry_a (
        .clk       (clk),
        .rst       (rst),
        .load      (a_load),
        .digit     (key_code),
        .shift_back(a_back),
        .clear     (a_clear),
        .value     (op_a),
        .count     (a_count)
    );

    operand_entry #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_entry_b (
        .clk       (clk),
        .rst       (rst),
        .load      (b_load),
        .digit     (key_code),
        .shift_back(b_back),
        .clear     (b_clear),
        .value     (op_b),
        .count     (b_count)
    );

    // Sequencer state machine with registered start, busy, error and display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTER_A;
            alu_start  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            disp_value <= '0;
            result     <= '0;
            timer      <= '0;
        end else begin
            alu_start <= 1'b0;
            if (key_clr) begin
                state      <= ENTER_A;
                busy       <= 1'b0;
                err        <= 1'b0;
                timer      <= '0;
                disp_value <= 16'(a_next);
            end else begin
                case (state)
                    ENTER_A: begin
                        if (key_op) begin
                            state      <= ENTER_B;
                            disp_value <= 16'(b_next);
                        end else begin
                            disp_value <= 16'(a_next);
                        end
                    end
                    ENTER_B: begin
                        if (key_eq) begin
                            state      <= START;
                            alu_start  <= 1'b1;
                            busy       <= 1'b1;
                            disp_value <= 16'(op_b);
`ifdef CALC_BACKSPACE_EN
                        end else if (key_bs && b_count == '0) begin
                            state      <= ENTER_A;
                            disp_value <= 16'(a_next);
`endif
                        end else begin
                            disp_value <= 16'(b_next);
                        end
                    end
                    START: begin
                        state      <= WAIT_DONE;
                        timer      <= '0;
                        disp_value <= 16'(op_b);
                    end
                    WAIT_DONE: begin
                        if (alu_done) begin
                            state      <= SHOW;
                            busy       <= 1'b0;
                            result     <= alu_result;
                            disp_value <= alu_result;
                        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            state      <= ERR;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                            disp_value <= ERR_PATTERN;
                        end else begin
                            timer      <= timer + 1'b1;
                            disp_value <= 16'(op_b);
                        end
                    end
                    SHOW: begin
                        if (key_digit) begin
                            state      <= ENTER_A;
                            disp_value <= 16'(a_next);
                        end else begin
                            disp_value <= result;
                        end
                    end
                    ERR: begin
                        disp_value <= ERR_PATTERN;
                    end
                    default: begin
                        state <= ENTER_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer.
// A digit-queue reference model predicts every registered output for each
// cycle; predictions are queued by the driver and popped by a monitor.
module tb_calc_sequencer;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        alu_start;
    logic [15:0] disp_value;
    logic        busy;
    logic        err;

    calc_sequencer #(
        .MAX_DIGITS    (3),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_start (alu_start),
        .disp_value(disp_value),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        start;
        logic [15:0] disp;
        logic        busy;
        logic        err;
    } snap_t;

    snap_t expq[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: operands as lists of entered digits.
    localparam int M_EA = 0, M_EB = 1, M_START = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;
    int          m_mode = M_EA;
    int          da[$];
    int          db[$];
    logic [15:0] m_result = 16'h0;
    int          m_timer = 0;
    bit          m_err = 1'b0;

    task automatic modelStep(input logic r, input logic kv, input logic [3:0] kc,
                             input logic dn, input logic [15:0] res);
        bit clr;
        bit dig;
        if (r) begin
            m_mode = M_EA; da.delete(); db.delete();
            m_result = 16'h0; m_timer = 0; m_err = 1'b0;
            return;
        end
        clr = kv && (kc == 4'hC);
        dig = kv && (kc <= 4'h9);
        if (clr) begin
            m_mode = M_EA; da.delete(); db.delete();
            m_timer = 0; m_err = 1'b0;
            return;
        end
        case (m_mode)
            M_EA: begin
                if (dig) begin
                    if (da.size() < 3) da.push_back(int'(kc));
                end else if (kv && kc == 4'hA) begin
                    m_mode = M_EB;
                end
`ifdef CALC_BACKSPACE_EN
                else if (kv && kc == 4'hB) begin
                    if (da.size() > 0) void'(da.pop_back());
                end
`endif
            end
            M_EB: begin
                if (dig) begin
                    if (db.size() < 3) db.push_back(int'(kc));
                end else if (kv && kc == 4'hE) begin
                    m_mode = M_START;
                end
`ifdef CALC_BACKSPACE_EN
                else if (kv && kc == 4'hB) begin
                    if (db.size() > 0) void'(db.pop_back());
                    else m_mode = M_EA;
                end
`endif
            end
            M_START: begin
                m_mode = M_WAIT;
                m_timer = 0;
            end
            M_WAIT: begin
                if (dn) begin
                    m_result = res;
                    m_mode = M_SHOW;
                end else begin
                    m_timer++;
                    if (m_timer == TIMEOUT) begin
                        m_mode = M_ERR;
                        m_err = 1'b1;
                    end
                end
            end
            M_SHOW: begin
                if (dig) begin
                    da.delete(); db.delete();
                    da.push_back(int'(kc));
                    m_mode = M_EA;
                end
            end
            default: begin
            end
        endcase
    endtask

    function automatic snap_t modelOutputs();
        snap_t s;
        logic [15:0] va;
        logic [15:0] vb;
        va = 16'h0;
        vb = 16'h0;
        foreach (da[i]) va = (va << 4) | 16'(da[i]);
        foreach (db[i]) vb = (vb << 4) | 16'(db[i]);
        s.a = va[11:0];
        s.b = vb[11:0];
        s.start = (m_mode == M_START);
        s.busy = (m_mode == M_START) || (m_mode == M_WAIT);
        s.err = m_err;
        case (m_mode)
            M_EA:             s.disp = va;
            M_EB:             s.disp = vb;
            M_START, M_WAIT:  s.disp = vb;
            M_SHOW:           s.disp = m_result;
            default:          s.disp = 16'hEEEE;
        endcase
        return s;
    endfunction

    // Drive one cycle of inputs and queue the predicted post-edge outputs.
    task automatic applyStimulus(input logic r, input logic kv, input logic [3:0] kc,
                                 input logic dn, input logic [15:0] res);
        snap_t s;
        @(negedge clk);
        rst = r;
        key_valid = kv;
        key_code = kc;
        alu_done = dn;
        alu_result = res;
        modelStep(r, kv, kc, dn, res);
        s = modelOutputs();
        @(posedge clk);
        expq.push_back(s);
    endtask

    task automatic pressKey(input logic [3:0] kc);
        applyStimulus(1'b0, 1'b1, kc, 1'b0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0);
    endtask

    task automatic aluDone(input logic [15:0] res);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, res);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction every cycle.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                s = expq.pop_front();
                vectors++;
                checkOutput("op_a", 16'(op_a), 16'(s.a));
                checkOutput("op_b", 16'(op_b), 16'(s.b));
                checkOutput("alu_start", 16'(alu_start), 16'(s.start));
                checkOutput("disp_value", disp_value, s.disp);
                checkOutput("busy", 16'(busy), 16'(s.busy));
                checkOutput("err", 16'(err), 16'(s.err));
            end
        end
    end

    initial begin
        logic        kv;
        logic [3:0]  kc;
        logic        dn;

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 16'h0);

        // Clear coincident with done: result must stay unlatched.
        pressKey(4'h1); pressKey(4'hA); pressKey(4'h2); pressKey(4'hE);
        idle(2);
        applyStimulus(1'b0, 1'b1, 4'hC, 1'b1, 16'h1998);
        idle(1);

        // Basic 123 + 456 with done three cycles after start, then new digit.
        pressKey(4'h1); pressKey(4'h2); pressKey(4'h3); pressKey(4'hA);
        pressKey(4'h4); pressKey(4'h5); pressKey(4'h6); pressKey(4'hE);
        idle(2);
        aluDone(16'h0579);
        idle(2);
        pressKey(4'hA); pressKey(4'hE);
        pressKey(4'h5);
        idle(1);

        // Digit saturation and empty operand B.
        pressKey(4'hC);
        pressKey(4'h9); pressKey(4'h8); pressKey(4'h7); pressKey(4'h6);
        pressKey(4'hA); pressKey(4'hE);
        idle(3);
        aluDone(16'h0987);
        pressKey(4'hC);

        // Backspace handling (build-dependent).
        pressKey(4'h1); pressKey(4'h2); pressKey(4'hB);
        pressKey(4'hA); pressKey(4'h7); pressKey(4'hB); pressKey(4'hB); pressKey(4'hB);
        idle(1);
        pressKey(4'hC);

        // Timeout, ignored keys in ERR, then clear.
        pressKey(4'h1); pressKey(4'hA); pressKey(4'hE);
        idle(TIMEOUT + 3);
        pressKey(4'h5); pressKey(4'hE);
        pressKey(4'hC);

        // Done on the timeout-terminal cycle wins.
        pressKey(4'h2); pressKey(4'hA); pressKey(4'h3); pressKey(4'hE);
        for (int i = 0; i < 20 && !(m_mode == M_WAIT && m_timer == TIMEOUT - 1); i++) idle(1);
        aluDone(16'h4321);
        idle(1);

        // Done outside WAIT_DONE is ignored; reset mid-operation drops done.
        pressKey(4'hC);
        aluDone(16'h1111);
        pressKey(4'h4); pressKey(4'hA); pressKey(4'h5); pressKey(4'hE);
        idle(2);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 16'h7777);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kv = ($urandom_range(0, 2) == 0);
            kc = 4'($urandom_range(0, 15));
            if (kc == 4'hC && $urandom_range(0, 3) != 0) kc = 4'($urandom_range(0, 9));
            if (m_mode == M_WAIT) dn = ($urandom_range(0, 5) == 0);
            else dn = ($urandom_range(0, 19) == 0);
            applyStimulus(1'b0, kv, kc, dn, 16'($urandom));
        end
        idle(2);

        @(negedge clk);
        key_valid = 1'b0;
        alu_done = 1'b0;
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Controller that sequences two-operand entry for the calculator datapath. It consumes one-cycle key strobes from the keypad/dipswitch front end and builds two 3-digit BCD operands digit by digit. On '=' it launches the arithmetic unit with a start/done handshake and captures the result. It also selects what the display driver shows, and sits between the input decoder and the ALU/7-segment path.

## Interface
- MAX_DIGITS, 3: digits per operand; operand width is 4*MAX_DIGITS.
- TIMEOUT_CYCLES, 1024: cycles allowed in WAIT_DONE before error; must be ≥2.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0x0–0x9 digit, 0xA operator (next operand), 0xB backspace, 0xC clear, 0xE equals, others ignored
- alu_done  in  1  one-cycle completion strobe from ALU
- alu_result  in  16  4-digit BCD result, valid when alu_done=1
- op_a  out  12  operand A, BCD, units in [3:0]
- op_b  out  12  operand B, BCD
- alu_start  out  1  one-cycle launch pulse
- disp_value  out  16  BCD value for display driver
- busy  out  1  high in START and WAIT_DONE
- err  out  1  timeout flag, sticky until clear or rst

## Operation
- States: ENTER_A, ENTER_B, START, WAIT_DONE, SHOW, ERR. Reset state is ENTER_A.
- Reset values: all outputs 0, result register 0, digit counts 0, timeout counter 0.
- Digit entry (ENTER_A/ENTER_B):
  - The selected operand shifts left 4 bits and the new digit enters at [3:0]; its count increments.
  - Once count = MAX_DIGITS, further digits are ignored. There is no wrap and no overwrite.
- ENTER_A: operator goes to ENTER_B, including with 0 digits entered (A=0). Equals is ignored.
- ENTER_B: equals goes to START, including with 0 digits entered (B=0). Operator is ignored.
- START lasts exactly one cycle with alu_start=1, then goes to WAIT_DONE. op_a and op_b are held stable from START until SHOW/ERR.
- WAIT_DONE:
  - On alu_done, alu_result is latched and the state goes to SHOW.
  - Otherwise the timeout counter increments; when it reaches TIMEOUT_CYCLES the state goes to ERR with err=1.
  - All keys except clear are ignored.
- SHOW: a digit key zeroes A, B and both counts, loads the digit into A, and goes to ENTER_A. Operator and equals are ignored.
- ERR: only clear is accepted.
- Clear (0xC), in any state: go to ENTER_A, zero A, B, counts, timeout counter and err. The result register is kept.
- disp_value:
  - ENTER_A: {4'h0, op_a}
  - ENTER_B: {4'h0, op_b}
  - START/WAIT_DONE: op_b
  - SHOW: result register
  - ERR: 16'hEEEE
- Simultaneous events:
  - clear and alu_done in the same cycle: clear wins and the result is not latched.
  - alu_done on the timeout-terminal cycle: done wins.
  - alu_done outside WAIT_DONE is ignored.

## Timing
- All outputs are registered.
- Key strobe at cycle n: operand, state and disp_value update at n+1.
- Equals at n: alu_start=1 during n+1 only, and WAIT_DONE begins at n+2.
- alu_done at m: SHOW and the new disp_value appear at m+1.
- No start without done → err=1 exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry.
- rst asserted mid-operation: reset values at the next edge, and any in-flight alu_done is dropped.

## Configuration
- CALC_BACKSPACE_EN defined: key 0xB in ENTER_A/ENTER_B shifts the active operand right 4 bits, zero-fills [11:8] and decrements its count.
  - Backspace with count 0 stays at operand 0 and count 0.
  - In ENTER_B with count 0, backspace returns to ENTER_A; operand A and its count are unchanged.
- Undefined: 0xB is ignored everywhere like any unlisted code.

## Structure
- calc_pkg holds:
  - the state enum typedef;
  - the key code constants KEY_OP, KEY_BS, KEY_CLR, KEY_EQ;
  - ERR_PATTERN = 16'hEEEE.
- Sub-module operand_entry is instantiated twice (A, B). It contains the BCD shift register plus a saturating digit counter, with ports load, digit, shift_back, clear, value and count.

## Test plan
- Keys 1,2,3,A,4,5,6,E, then alu_done with 0x0579 three cycles after start → op_a=0x123, op_b=0x456, a single alu_start pulse, disp_value=0x0579 in SHOW.
- Keys 9,8,7,6 → op_a=0x987, 6 ignored. Then A,E → op_b=0x000 and a start pulse is issued.
- Keys 1,2,B:
  - with CALC_BACKSPACE_EN → op_a=0x001;
  - without → op_a=0x012.
- TIMEOUT_CYCLES=8, equals and no done → err=1 and disp_value=0xEEEE 8 cycles after WAIT_DONE entry; clear → err=0, ENTER_A.
- In WAIT_DONE, clear coincident with alu_done=1, alu_result=0x1998 → ENTER_A, result register unchanged (0x0000), no SHOW.
- In SHOW, key 5 → ENTER_A, op_a=0x005, op_b=0x000, disp_value=0x0005.
